// File: rtl/md_unit_ctrl_if.sv
// EX-stage <-> multiply/divide unit connection: the instruction request, flush,
// and the stall / commit / HI-LO results returned to the pipeline.
interface md_unit_ctrl_if;
    logic        md_valid;
    logic [2:0]  md_op;
    logic [31:0] md_input1;
    logic [31:0] md_input2;
    logic        flush;
    logic        md_stall;
    logic        md_done;
    logic        div_by_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output md_valid, md_op, md_input1, md_input2, flush,
        input  md_stall, md_done, div_by_zero, hi_out, lo_out
    );

    modport slave (
        input  md_valid, md_op, md_input1, md_input2, flush,
        output md_stall, md_done, div_by_zero, hi_out, lo_out
    );
endinterface

// File: rtl/md_unit_ctrl.sv
// MIPS HI/LO sequencer: fixed-latency multiply, 32-step restoring divide,
// MTHI/MTLO, pipeline stall and flush-safe architectural HI/LO ownership.
module md_unit_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int CNT_WIDTH  = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    md_unit_ctrl_if.slave md
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DIV_FIX, S_COMMIT} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [63:0]            mul_a_q, mul_a_d, mul_b_q, mul_b_d, prod_q, prod_d;
    logic [31:0]            rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic                   q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic                   is_mul_q, is_mul_d, dbz_q, dbz_d;
    logic [31:0]            hi_q, hi_d, lo_q, lo_d;

    // Operands are pre-extended to 64 bits, so the low 64 bits of an unsigned
    // product are correct for both MULT and MULTU.
    logic [63:0] prod_full;
    logic [32:0] trial_sh, trial_diff;
    logic        in1_neg, in2_neg, is_signed;
    logic [31:0] in1_abs, in2_abs;

    assign prod_full  = mul_a_q * mul_b_q;
    assign trial_sh   = {rem_q, quo_q[31]};
    assign trial_diff = trial_sh - {1'b0, dvsr_q};

    assign is_signed = (md.md_op == OP_MULT) || (md.md_op == OP_DIV);
    assign in1_neg   = is_signed && md.md_input1[31];
    assign in2_neg   = is_signed && md.md_input2[31];
    assign in1_abs   = in1_neg ? (~md.md_input1 + 32'd1) : md.md_input1;
    assign in2_abs   = in2_neg ? (~md.md_input2 + 32'd1) : md.md_input2;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        is_mul_d = is_mul_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE: begin
                if (md.md_valid) begin
                    case (md.md_op)
                        OP_MULT, OP_MULTU: begin
                            mul_a_d  = in1_neg ? {32'hFFFF_FFFF, md.md_input1} : {32'd0, md.md_input1};
                            mul_b_d  = in2_neg ? {32'hFFFF_FFFF, md.md_input2} : {32'd0, md.md_input2};
                            is_mul_d = 1'b1;
                            dbz_d    = 1'b0;
                            cnt_d    = CNT_WIDTH'(MUL_CYCLES - 1);
                            state_d  = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            is_mul_d = 1'b0;
                            if (md.md_input2 == 32'd0) begin
                                rem_d   = md.md_input1;
                                quo_d   = 32'hFFFF_FFFF;
                                dbz_d   = 1'b1;
                                state_d = S_COMMIT;
                            end else begin
                                rem_d   = 32'd0;
                                quo_d   = in1_abs;
                                dvsr_d  = in2_abs;
                                q_neg_d = in1_neg ^ in2_neg;
                                r_neg_d = in1_neg;
                                dbz_d   = 1'b0;
                                cnt_d   = CNT_WIDTH'(31);
                                state_d = S_DIV;
                            end
                        end
                        OP_MTHI: hi_d = md.md_input1;
                        OP_MTLO: lo_d = md.md_input1;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                prod_d = prod_full;
                if (cnt_q == '0) state_d = S_COMMIT;
                else             cnt_d   = cnt_q - CNT_WIDTH'(1);
            end
            S_DIV: begin
                // Restoring step: keep the subtraction only if it did not go negative.
                if (!trial_diff[32]) rem_d = trial_diff[31:0];
                else                 rem_d = trial_sh[31:0];
                quo_d = {quo_q[30:0], ~trial_diff[32]};
                if (cnt_q == '0) state_d = S_DIV_FIX;
                else             cnt_d   = cnt_q - CNT_WIDTH'(1);
            end
            S_DIV_FIX: begin
                if (q_neg_q) quo_d = ~quo_q + 32'd1;
                if (r_neg_q) rem_d = ~rem_q + 32'd1;
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                hi_d    = is_mul_q ? prod_q[63:32] : rem_q;
                lo_d    = is_mul_q ? prod_q[31:0]  : quo_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (md.flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_mul_q <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            is_mul_q <= is_mul_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Stall drops in COMMIT so the held instruction advances on the commit edge.
    assign md.md_stall = ((state_q == S_IDLE) && md.md_valid &&
                          (md.md_op == OP_MULT || md.md_op == OP_MULTU ||
                           md.md_op == OP_DIV  || md.md_op == OP_DIVU)) ||
                         (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_DIV_FIX);
    assign md.md_done     = (state_q == S_COMMIT) && !md.flush;
    assign md.div_by_zero = (state_q == S_COMMIT) && !md.flush && dbz_q;
    assign md.hi_out      = hi_q;
    assign md.lo_out      = lo_q;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: directed MIPS multiply/divide/MTxx/flush/reset vectors,
// checked each cycle against an arithmetic model and against hand-computed literals.
module tb_md_unit_ctrl;
    localparam int MUL_CYCLES = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    md_unit_ctrl_if ifc();

    md_unit_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CNT_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (ifc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} straight from MIPS arithmetic rules.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (op)
            3'd1: r = 64'(sa * sb);
            3'd2: r = ua * ub;
            3'd3: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            3'd4: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {32'(ua % ub), 32'(ua / ub)};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Model: busy cycles remaining, commit pending, pending result, HI/LO.
    int          m_cnt    = 0;
    bit          m_commit = 1'b0;
    bit          m_dbz    = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_commit <= 1'b0; m_dbz <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_phi <= '0; m_plo <= '0;
        end else if (ifc.flush) begin
            m_cnt <= 0; m_commit <= 1'b0;
        end else if (m_commit) begin
            m_hi <= m_phi; m_lo <= m_plo; m_commit <= 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_commit <= 1'b1;
        end else if (ifc.md_valid) begin
            case (ifc.md_op)
                3'd1, 3'd2: begin
                    {m_phi, m_plo} <= ref_result(ifc.md_op, ifc.md_input1, ifc.md_input2);
                    m_dbz <= 1'b0;
                    m_cnt <= MUL_CYCLES;
                end
                3'd3, 3'd4: begin
                    {m_phi, m_plo} <= ref_result(ifc.md_op, ifc.md_input1, ifc.md_input2);
                    if (ifc.md_input2 == 32'd0) begin
                        m_dbz <= 1'b1; m_commit <= 1'b1;
                    end else begin
                        m_dbz <= 1'b0; m_cnt <= 33;
                    end
                end
                3'd5: m_hi <= ifc.md_input1;
                3'd6: m_lo <= ifc.md_input1;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cyc_stall", 64'(ifc.md_stall),
            64'((m_cnt > 0) || (!m_commit && ifc.md_valid && ifc.md_op >= 3'd1 && ifc.md_op <= 3'd4)));
        chk("cyc_done", 64'(ifc.md_done), 64'(m_commit && !ifc.flush));
        chk("cyc_dbz", 64'(ifc.div_by_zero), 64'(m_commit && !ifc.flush && m_dbz));
        chk("cyc_hi", 64'(ifc.hi_out), 64'(m_hi));
        chk("cyc_lo", 64'(ifc.lo_out), 64'(m_lo));
    end

    // Entered just after a rising edge; returns just after the commit edge.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stalls, input logic exp_dbz,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int stalls = 0;
        bit done   = 1'b0;
        bit dbz    = 1'b0;
        ifc.md_valid = 1'b1; ifc.md_op = op; ifc.md_input1 = a; ifc.md_input2 = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (ifc.md_stall) stalls++;
            if (ifc.md_done) begin done = 1'b1; dbz = ifc.div_by_zero; end
            @(posedge clk); #1;
        end
        ifc.md_valid = 1'b0; ifc.md_op = 3'd0;
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_stalls"}, 64'(stalls), 64'(exp_stalls));
        chk({name, "_dbz"}, 64'(dbz), 64'(exp_dbz));
        chk({name, "_hi"}, 64'(ifc.hi_out), 64'(exp_hi));
        chk({name, "_lo"}, 64'(ifc.lo_out), 64'(exp_lo));
        $display("op %s a=0x%08h b=0x%08h stalls=%0d hi=0x%08h lo=0x%08h",
                 name, a, b, stalls, ifc.hi_out, ifc.lo_out);
    endtask

    task automatic mt_op(input logic [2:0] op, input logic [31:0] a);
        ifc.md_valid = 1'b1; ifc.md_op = op; ifc.md_input1 = a;
        @(negedge clk);
        chk("mt_stall", 64'(ifc.md_stall), 64'd0);
        @(posedge clk); #1;
        ifc.md_valid = 1'b0; ifc.md_op = 3'd0;
        $display("op mt%s value=0x%08h hi=0x%08h lo=0x%08h", (op == 3'd5) ? "hi" : "lo",
                 a, ifc.hi_out, ifc.lo_out);
    endtask

    int done_cnt;

    initial begin
        ifc.md_valid = 1'b0; ifc.md_op = 3'd0; ifc.md_input1 = '0; ifc.md_input2 = '0;
        ifc.flush = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 64'(ifc.md_stall), 64'd0);
        chk("rst_done", 64'(ifc.md_done), 64'd0);
        chk("rst_dbz", 64'(ifc.div_by_zero), 64'd0);
        chk("rst_hi", 64'(ifc.hi_out), 64'd0);
        chk("rst_lo", 64'(ifc.lo_out), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd5, 3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        mt_op(3'd6, 32'h1234_5678);
        chk("mtlo_lo", 64'(ifc.lo_out), 64'h1234_5678);
        chk("mtlo_hi", 64'(ifc.hi_out), 64'hFFFF_FFFE);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 34, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b0, 32'h0, 32'h8000_0000);
        run_op("div_negdiv", 3'd3, 32'd7, 32'hFFFF_FFFE, 34, 1'b0, 32'd1, 32'hFFFF_FFFD);
        run_op("divu_big", 3'd4, 32'hFFFF_FFFF, 32'h10, 34, 1'b0, 32'hF, 32'h0FFF_FFFF);
        run_op("divu_zero", 3'd4, 32'h0000_1234, 32'd0, 1, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("mult_pos", 3'd1, 32'd7, 32'd6, 3, 1'b0, 32'd0, 32'd42);

        // Flush at the 10th DIV cycle.
        mt_op(3'd5, 32'hAAAA_0000);
        done_cnt = 0;
        ifc.md_valid = 1'b1; ifc.md_op = 3'd4; ifc.md_input1 = 32'd100; ifc.md_input2 = 32'd7;
        @(posedge clk); #1;
        repeat (9) begin
            @(negedge clk); if (ifc.md_done) done_cnt++;
            @(posedge clk); #1;
        end
        ifc.flush = 1'b1; ifc.md_valid = 1'b0; ifc.md_op = 3'd0;
        @(negedge clk); if (ifc.md_done) done_cnt++;
        @(posedge clk); #1;
        ifc.flush = 1'b0;
        @(negedge clk);
        chk("flush_stall", 64'(ifc.md_stall), 64'd0);
        repeat (4) begin
            if (ifc.md_done) done_cnt++;
            @(negedge clk);
        end
        chk("flush_done_cnt", 64'(done_cnt), 64'd0);
        chk("flush_hi", 64'(ifc.hi_out), 64'hAAAA_0000);
        chk("flush_lo", 64'(ifc.lo_out), 64'd42);
        $display("op flush_div hi=0x%08h lo=0x%08h done_pulses=%0d", ifc.hi_out, ifc.lo_out, done_cnt);

        // Flush coincident with COMMIT of a divide-by-zero.
        @(posedge clk); #1;
        ifc.md_valid = 1'b1; ifc.md_op = 3'd4; ifc.md_input1 = 32'h5555; ifc.md_input2 = 32'd0;
        @(posedge clk); #1;
        ifc.flush = 1'b1; ifc.md_valid = 1'b0; ifc.md_op = 3'd0;
        @(negedge clk);
        chk("cflush_done", 64'(ifc.md_done), 64'd0);
        @(posedge clk); #1;
        ifc.flush = 1'b0;
        chk("cflush_hi", 64'(ifc.hi_out), 64'hAAAA_0000);
        chk("cflush_lo", 64'(ifc.lo_out), 64'd42);
        $display("op flush_commit hi=0x%08h lo=0x%08h", ifc.hi_out, ifc.lo_out);

        // Asynchronous reset in the middle of a divide.
        ifc.md_valid = 1'b1; ifc.md_op = 3'd4; ifc.md_input1 = 32'd100; ifc.md_input2 = 32'd7;
        @(posedge clk); #1;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        ifc.md_valid = 1'b0; ifc.md_op = 3'd0;
        #1 chk("arst_busy", 64'(ifc.md_stall), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_stall", 64'(ifc.md_stall), 64'd0);
        chk("arst_hi", 64'(ifc.hi_out), 64'd0);
        chk("arst_lo", 64'(ifc.lo_out), 64'd0);
        $display("op async_reset stall=%0b hi=0x%08h lo=0x%08h", ifc.md_stall, ifc.hi_out, ifc.lo_out);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("divu_after_rst", 3'd4, 32'd100, 32'd7, 34, 1'b0, 32'd2, 32'd14);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Execute-stage sequencer for the MIPS HI/LO multiply/divide resource.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage alongside the ALU and runs a multi-cycle multiply (fixed latency) or a 32-step radix-2 restoring divide.
- Holds the pipeline via md_stall until the result commits, and owns the architectural HI/LO registers.
- Supports flush on exception/trap so an aborted instruction never writes HI/LO.

Parameters:
- MUL_CYCLES, 2, cycles spent in MUL state before commit (legal range 1..15).
- CNT_WIDTH, 5, width of the iteration/latency counter (must hold max(MUL_CYCLES,31)).

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- md_valid  input  1  EX stage holds a valid md instruction this cycle.
- md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- md_input1  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- md_input2  input  32  rt operand (divisor / multiplier).
- flush  input  1  synchronous abort of the in-flight operation.
- md_stall  output  1  hold IF/ID/EX this cycle.
- md_done  output  1  one-cycle pulse in COMMIT.
- div_by_zero  output  1  high in COMMIT of a DIV/DIVU with zero divisor.
- hi_out  output  32  current HI register.
- lo_out  output  32  current LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, HI=LO=0, counter=0, operand/partial registers=0. Outputs md_stall=0, md_done=0, div_by_zero=0.
- States: IDLE, MUL, DIV, DIV_FIX, COMMIT.
- Issue happens only in IDLE, when md_valid=1 and flush=0:
  - MULT/MULTU: latch operands (sign-extend for MULT, zero-extend for MULTU), counter=MUL_CYCLES-1, go to MUL.
  - DIV/DIVU with md_input2 != 0: latch |input1| and |input2| (DIV; 0x80000000 stays 0x80000000 as unsigned), record quotient sign = s1^s2 and remainder sign = s1, counter=31, go to DIV.
  - DIV/DIVU with md_input2 == 0: result HI=md_input1, LO=32'hFFFFFFFF, go directly to COMMIT.
  - MTHI/MTLO: HI (or LO)=md_input1 at that edge, stay IDLE, no stall.
- MUL: 64-bit product is formed and held in a register. Decrement counter; when counter==0, go to COMMIT with HI=product[63:32], LO=product[31:0].
- DIV: one restoring step per cycle (shift remainder:quotient left 1, trial subtract, set quotient bit). When counter==0, go to DIV_FIX.
- DIV_FIX: for DIV, negate quotient if the quotient sign is 1, and negate remainder if the remainder sign is 1. DIVU passes through unchanged. Then go to COMMIT.
- COMMIT: md_done=1 and div_by_zero as recorded. HI/LO are written at the edge leaving COMMIT. Next state is IDLE. md_valid is ignored in COMMIT, since it is the same held instruction.
- md_stall (combinational):
  - 1 in IDLE when md_valid && op is MULT/MULTU/DIV/DIVU.
  - 1 in MUL, DIV, DIV_FIX.
  - 0 in COMMIT, so the instruction advances on the commit edge.
  - 0 otherwise.
- Stall-cycle counts:
  - MULT/MULTU: 1+MUL_CYCLES.
  - DIV/DIVU: 1+32+1 = 34.
  - Divide by zero: 1.
- hi_out/lo_out are direct register outputs. An MFHI/MFLO in the cycle after COMMIT sees the new value.
- flush=1 in any state: next state=IDLE, HI/LO unchanged, no md_done. Flush overrides issue, MTHI/MTLO writes and COMMIT writes.
- md_valid outside IDLE/COMMIT is ignored (upstream is stalled and holds it).
- Arithmetic wraps mod 2^32: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Reset asserted mid-operation: immediate return to reset values, with no partial HI/LO write.

Test Plan:
- Reset, then MULT input1=0xFFFFFFFD, input2=5 (MUL_CYCLES=2) -> md_stall high 3 cycles, md_done on 4th cycle, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; followed next cycle by MTLO 0x12345678 -> LO=0x12345678, no stall.
- DIV 0xFFFFFFF9 / 2 -> stall exactly 34 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x00001234 / 0 -> 1 stall cycle, div_by_zero=1 with md_done, then HI=0x00001234, LO=0xFFFFFFFF.
- Preload HI=0xAAAA0000. DIVU 100/7 with flush at 10th DIV cycle -> IDLE next cycle, md_stall=0, md_done never pulses, HI still 0xAAAA0000. Flush coincident with COMMIT also leaves HI/LO unchanged.
- rst_n pulsed low mid-DIV (async, between edges) -> md_stall drops immediately, HI=LO=0. The next DIVU 100/7 completes normally with LO=14, HI=2.
